// File: rtl/axi_lite_cmd_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axi_lite_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_WR_RESP   = 3'd2,
    ST_READ_ADDR = 3'd3,
    ST_RD_DATA   = 3'd4
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY_C   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR_C = 2'b10;

  // The timeout counter is never narrower than 16 bits.
  function automatic int timeout_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 16) ? 16 : w;
  endfunction

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by write/read command pulses,
// with a bring-up timeout that forces an abort when the slave stalls.
module axi_lite_cmd_master
  import axi_lite_cmd_pkg::*;
#(
  parameter int AXI_DATA_WIDTH_C = 32,
  parameter int AXI_ADDR_WIDTH_C = 32,
  parameter int TIMEOUT_C        = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_write,
  input  logic                            cmd_read,
  input  logic [AXI_ADDR_WIDTH_C-1:0]     cmd_addr,
  input  logic [AXI_DATA_WIDTH_C-1:0]     cmd_wdata,
  input  logic [AXI_DATA_WIDTH_C/8-1:0]   cmd_wstrb,
  output logic                            cmd_busy,
  output logic                            cmd_done,
  output logic [1:0]                      cmd_resp,
  output logic [AXI_DATA_WIDTH_C-1:0]     cmd_rdata,
  output logic                            cmd_timeout,
  output logic [AXI_ADDR_WIDTH_C-1:0]     awaddr,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [AXI_DATA_WIDTH_C-1:0]     wdata,
  output logic [AXI_DATA_WIDTH_C/8-1:0]   wstrb,
  output logic                            wvalid,
  input  logic                            wready,
  input  logic [1:0]                      bresp,
  input  logic                            bvalid,
  output logic                            bready,
  output logic [AXI_ADDR_WIDTH_C-1:0]     araddr,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [AXI_DATA_WIDTH_C-1:0]     rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rvalid,
  output logic                            rready
);

  localparam int STRB_W_C = AXI_DATA_WIDTH_C / 8;
  localparam int CNT_W_C  = timeout_cnt_width(TIMEOUT_C);
  localparam logic [CNT_W_C-1:0] CNT_LAST_C = (TIMEOUT_C > 0) ? CNT_W_C'(TIMEOUT_C - 1) : '0;
  localparam logic [CNT_W_C-1:0] CNT_MAX_C  = '1;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH_C-1:0] awaddr_q, awaddr_d;
  logic [AXI_ADDR_WIDTH_C-1:0] araddr_q, araddr_d;
  logic [AXI_DATA_WIDTH_C-1:0] wdata_q, wdata_d;
  logic [STRB_W_C-1:0]         wstrb_q, wstrb_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        bready_q, bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        timeout_q, timeout_d;
  logic [1:0]                  resp_q, resp_d;
  logic [AXI_DATA_WIDTH_C-1:0] rdata_q, rdata_d;
  logic [CNT_W_C-1:0]          cnt_q, cnt_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, expire, abort;

  always_comb begin
    aw_hs  = awvalid_q & awready;
    w_hs   = wvalid_q & wready;
    b_hs   = bready_q & bvalid;
    ar_hs  = arvalid_q & arready;
    r_hs   = rready_q & rvalid;
    any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    // Any handshake on the expiry edge takes priority over the abort.
    expire = (TIMEOUT_C > 0) && (cnt_q >= CNT_LAST_C) && !any_hs;

    state_d   = state_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    abort     = 1'b0;
    cnt_d     = (busy_q && (cnt_q != CNT_MAX_C)) ? cnt_q + 1'b1 : cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_write || cmd_read) begin
          awaddr_d = cmd_addr;
          araddr_d = cmd_addr;
          wdata_d  = cmd_wdata;
          wstrb_d  = cmd_wstrb;
          busy_d   = 1'b1;
          cnt_d    = '0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_READ_ADDR;
          end
        end
      end
      ST_WRITE: begin
        if (expire) begin
          abort = 1'b1;
        end else begin
          if (aw_hs) awvalid_d = 1'b0;
          if (w_hs)  wvalid_d  = 1'b0;
          if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
            bready_d = 1'b1;
            state_d  = ST_WR_RESP;
          end
        end
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          resp_d   = bresp;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_READ_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (r_hs) begin
          rready_d = 1'b0;
          rdata_d  = rdata;
          resp_d   = rresp;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      resp_d    = AXI_RESP_SLVERR_C;
      done_d    = 1'b1;
      timeout_d = 1'b1;
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      resp_q    <= AXI_RESP_OKAY_C;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cmd_busy    = busy_q;
  assign cmd_done    = done_q;
  assign cmd_resp    = resp_q;
  assign cmd_rdata   = rdata_q;
  assign cmd_timeout = timeout_q;
  assign awaddr      = awaddr_q;
  assign awvalid     = awvalid_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign wvalid      = wvalid_q;
  assign bready      = bready_q;
  assign araddr      = araddr_q;
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Randomized bench for axi_lite_cmd_master: a reactive AXI4-Lite slave with
// a small memory, plus a transaction-level model checked every cycle.
module tb_axi_lite_cmd_master;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_write, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        cmd_busy, cmd_done, cmd_timeout;
  logic [1:0]  cmd_resp;
  logic [31:0] cmd_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(
    .AXI_DATA_WIDTH_C(32), .AXI_ADDR_WIDTH_C(32), .TIMEOUT_C(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_write(cmd_write), .cmd_read(cmd_read), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_resp(cmd_resp),
    .cmd_rdata(cmd_rdata), .cmd_timeout(cmd_timeout),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        exp_busy, exp_done, exp_timeout;
  logic        exp_awvalid, exp_wvalid, exp_arvalid, exp_bready, exp_rready;
  logic [1:0]  exp_resp;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  int          elapsed;

  task automatic model_reset();
    exp_busy = 0; exp_done = 0; exp_timeout = 0;
    exp_awvalid = 0; exp_wvalid = 0; exp_arvalid = 0; exp_bready = 0; exp_rready = 0;
    exp_resp = 2'b00; exp_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
    elapsed = 0;
  endtask

  task automatic model_edge();
    logic hs_aw, hs_w, hs_ar, hs_b, hs_r;
    exp_done = 0;
    exp_timeout = 0;
    if (!exp_busy) begin
      if (cmd_write || cmd_read) begin
        exp_busy = 1; elapsed = 0;
        exp_addr = cmd_addr; exp_wdata = cmd_wdata; exp_wstrb = cmd_wstrb;
        if (cmd_write) begin exp_awvalid = 1; exp_wvalid = 1; end
        else exp_arvalid = 1;
      end
    end else begin
      hs_aw = exp_awvalid && awready;
      hs_w  = exp_wvalid && wready;
      hs_ar = exp_arvalid && arready;
      hs_b  = exp_bready && bvalid;
      hs_r  = exp_rready && rvalid;
      if (hs_b) begin
        exp_bready = 0; exp_resp = bresp; exp_done = 1; exp_busy = 0;
      end else if (hs_r) begin
        exp_rready = 0; exp_resp = rresp; exp_rdata = rdata; exp_done = 1; exp_busy = 0;
      end else if (T > 0 && elapsed + 1 >= T && !(hs_aw || hs_w || hs_ar)) begin
        exp_awvalid = 0; exp_wvalid = 0; exp_arvalid = 0; exp_bready = 0; exp_rready = 0;
        exp_resp = 2'b10; exp_done = 1; exp_timeout = 1; exp_busy = 0;
      end else begin
        if (hs_aw) exp_awvalid = 0;
        if (hs_w)  exp_wvalid = 0;
        if (hs_ar) begin exp_arvalid = 0; exp_rready = 1; end
        if (!exp_awvalid && !exp_wvalid && !exp_arvalid && !exp_rready) exp_bready = 1;
        elapsed++;
      end
    end
  endtask

  // ---------------- reactive slave ----------------
  logic [31:0] mem [16];
  int          aw_mode, w_mode, ar_mode, resp_mode, ready_pct;
  bit          aw_got, w_got, ar_got, b_pend, r_pend;
  logic [31:0] sl_awaddr, sl_wdata, sl_araddr;
  logic [3:0]  sl_wstrb;
  logic [1:0]  sl_bresp, sl_rresp;
  logic [31:0] sl_rdata;
  int          b_wait, b_delay, r_wait, r_delay;
  int          ar_hs_cnt, b_hs_cnt;
  logic        s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
  logic        s_done, s_timeout, s_busy;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_resp;

  function automatic int pick_delay();
    if (resp_mode == 1) return 0;
    if (resp_mode == 2) return 1000000;
    return ($urandom_range(0, 99) < 3) ? 1000000 : int'($urandom_range(0, 3));
  endfunction

  function automatic logic rdy(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return ($urandom_range(0, 99) < ready_pct) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [1:0] pick_resp();
    if (resp_mode != 0) return 2'b00;
    return ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
  endfunction

  task automatic slave_clear();
    aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
    b_wait = 0; r_wait = 0; b_delay = pick_delay(); r_delay = pick_delay();
  endtask

  task automatic slave_reset();
    slave_clear();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 2'b00; rresp = 2'b00; rdata = '0;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
    s_done = 0; s_timeout = 0; s_busy = 0;
  endtask

  task automatic slave_edge();
    if (s_awvalid && awready) begin aw_got = 1; sl_awaddr = s_awaddr; end
    if (s_wvalid && wready) begin w_got = 1; sl_wdata = s_wdata; sl_wstrb = s_wstrb; end
    if (s_arvalid && arready) begin ar_got = 1; sl_araddr = s_araddr; ar_hs_cnt++; end
    if (bvalid && s_bready) begin
      for (int b = 0; b < 4; b++)
        if (sl_wstrb[b]) mem[sl_awaddr[5:2]][8*b +: 8] = sl_wdata[8*b +: 8];
      b_hs_cnt++;
      aw_got = 0; w_got = 0; b_pend = 0; b_wait = 0; b_delay = pick_delay();
    end
    if (rvalid && s_rready) begin
      ar_got = 0; r_pend = 0; r_wait = 0; r_delay = pick_delay();
    end
  endtask

  task automatic slave_drive();
    if (s_timeout) slave_clear();
    if (aw_got && w_got && !b_pend) begin
      if (b_wait >= b_delay) begin b_pend = 1; sl_bresp = pick_resp(); end
      else b_wait++;
    end
    if (ar_got && !r_pend) begin
      if (r_wait >= r_delay) begin
        r_pend = 1; sl_rresp = pick_resp(); sl_rdata = mem[sl_araddr[5:2]];
      end else r_wait++;
    end
    awready = rdy(aw_mode);
    wready  = rdy(w_mode);
    arready = rdy(ar_mode);
    bvalid  = b_pend;
    bresp   = b_pend ? sl_bresp : 2'b00;
    rvalid  = r_pend;
    rresp   = r_pend ? sl_rresp : 2'b00;
    rdata   = r_pend ? sl_rdata : 32'h0;
  endtask

  // One clock: model and slave advance at the edge, inputs change at negedge.
  task automatic step(input bit inject_rst = 1'b0);
    @(posedge clk);
    if (rst_n) begin
      model_edge();
      slave_edge();
    end
    if (inject_rst) begin
      #2;
      rst_n = 1'b0;
      model_reset();
      slave_reset();
      #1;
      chk("rst_async_busy", cmd_busy, 64'd0);
      chk("rst_async_rready", rready, 64'd0);
      chk("rst_async_rdata", cmd_rdata, 64'd0);
    end
    @(negedge clk);
    s_awvalid = awvalid; s_wvalid = wvalid; s_arvalid = arvalid;
    s_bready = bready; s_rready = rready;
    s_awaddr = awaddr; s_wdata = wdata; s_wstrb = wstrb; s_araddr = araddr;
    s_done = cmd_done; s_timeout = cmd_timeout; s_busy = cmd_busy;
    s_rdata = cmd_rdata; s_resp = cmd_resp;
    slave_drive();
  endtask

  task automatic issue(input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    cmd_write = w; cmd_read = r; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    step();
    cmd_write = 0; cmd_read = 0;
  endtask

  // n counts clock edges from the accepting edge (inclusive) to done visibility.
  task automatic wait_done(input int budget, output int n);
    n = 1;
    while (!s_done && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", s_done, 64'd1);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", cmd_busy, exp_busy);
      chk("done", cmd_done, exp_done);
      chk("timeout", cmd_timeout, exp_timeout);
      chk("resp", cmd_resp, exp_resp);
      chk("rdata", cmd_rdata, exp_rdata);
      chk("awvalid", awvalid, exp_awvalid);
      chk("wvalid", wvalid, exp_wvalid);
      chk("arvalid", arvalid, exp_arvalid);
      chk("bready", bready, exp_bready);
      chk("rready", rready, exp_rready);
      if (exp_awvalid) chk("awaddr", awaddr, exp_addr);
      if (exp_wvalid) begin
        chk("wdata", wdata, exp_wdata);
        chk("wstrb", wstrb, exp_wstrb);
      end
      if (exp_arvalid) chk("araddr", araddr, exp_addr);
      if (!rst_n) begin
        chk("rst_awaddr", awaddr, 64'd0);
        chk("rst_araddr", araddr, 64'd0);
        chk("rst_wdata", wdata, 64'd0);
      end
    end
  end

  initial begin
    int n;
    cmd_write = 0; cmd_read = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    aw_mode = 1; w_mode = 1; ar_mode = 1; resp_mode = 1; ready_pct = 70;
    ar_hs_cnt = 0; b_hs_cnt = 0;
    sl_awaddr = '0; sl_wdata = '0; sl_araddr = '0; sl_wstrb = '0;
    sl_bresp = '0; sl_rresp = '0; sl_rdata = '0;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0; s_rdata = '0; s_resp = '0;
    slave_reset();
    model_reset();
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) step();
    chk("reset_busy", cmd_busy, 64'd0);
    chk("reset_awvalid", awvalid, 64'd0);
    chk("reset_rdata", cmd_rdata, 64'd0);
    rst_n = 1'b1;
    step();

    // Zero-wait write then readback
    b_hs_cnt = 0;
    issue(1, 0, 32'h4, 32'hDEAD_BEEF, 4'hF);
    wait_done(40, n);
    chk("wr_cmd_to_done_cycles", n, 64'd3);
    chk("wr_bresp", s_resp, 64'd0);
    chk("wr_one_b", b_hs_cnt, 64'd1);
    issue(0, 1, 32'h4, 32'h0, 4'h0);
    wait_done(40, n);
    chk("rd_cmd_to_done_cycles", n, 64'd3);
    chk("readback_rdata", s_rdata, 64'hDEAD_BEEF);

    // Read of preloaded register; done must be a single pulse
    mem[5] = 32'h0000_002A;
    issue(0, 1, 32'h14, 32'h0, 4'h0);
    wait_done(40, n);
    chk("rd_2a_rdata", s_rdata, 64'h2A);
    chk("rd_2a_resp", s_resp, 64'd0);
    step();
    chk("rd_done_single", s_done, 64'd0);

    // W accepted well before AW
    b_hs_cnt = 0;
    aw_mode = 2;
    issue(1, 0, 32'h8, 32'h1234_5678, 4'h3);
    repeat (3) step();
    chk("early_w_wvalid", s_wvalid, 64'd0);
    chk("early_w_awvalid", s_awvalid, 64'd1);
    aw_mode = 1;
    wait_done(40, n);
    chk("early_w_one_b", b_hs_cnt, 64'd1);

    // Write and read together, then a read while busy: only the write runs
    ar_hs_cnt = 0; b_hs_cnt = 0;
    issue(1, 1, 32'h10, 32'hA5A5_0001, 4'hF);
    cmd_read = 1; cmd_addr = 32'h14;
    step();
    cmd_read = 0;
    wait_done(40, n);
    repeat (3) step();
    chk("dual_no_ar", ar_hs_cnt, 64'd0);
    chk("dual_one_b", b_hs_cnt, 64'd1);
    chk("write_keeps_rdata", s_rdata, 64'h2A);

    // Slave never answers the write response
    resp_mode = 2; slave_clear();
    issue(1, 0, 32'h18, 32'h0BAD_0BAD, 4'hF);
    wait_done(60, n);
    chk("timeout_edges_after_accept", n - 1, 64'd16);
    chk("timeout_pulse", s_timeout, 64'd1);
    chk("timeout_resp", s_resp, 64'h2);
    chk("timeout_awvalid", s_awvalid, 64'd0);
    chk("timeout_bready", s_bready, 64'd0);
    step();
    chk("timeout_pulse_single", s_timeout, 64'd0);

    // Reset while waiting for read data, then a normal read
    issue(0, 1, 32'h20, 32'h0, 4'h0);
    step();
    chk("rd_data_rready", s_rready, 64'd1);
    step(1'b1);
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", s_busy, 64'd0);
    resp_mode = 1; slave_clear();
    mem[3] = 32'h0000_55AA;
    issue(0, 1, 32'hC, 32'h0, 4'h0);
    wait_done(40, n);
    chk("post_rst_rd_cycles", n, 64'd3);
    chk("post_rst_rdata", s_rdata, 64'h55AA);

    // Randomized traffic with random ready/response timing
    aw_mode = 0; w_mode = 0; ar_mode = 0; resp_mode = 0; slave_clear();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cmd_write = 1'($urandom_range(0, 1));
        cmd_read  = 1'($urandom_range(0, 1));
        cmd_addr  = {26'd0, 6'($urandom)};
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
      end else begin
        cmd_write = 0; cmd_read = 0;
      end
      step();
    end
    cmd_write = 0; cmd_read = 0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
